ysyx_25060173_alu_arb: RTL and testbench

Sequencer and round-robin arbiter that shares the single 32-bit ALU (ysyx_25060173_alu) between two requesters, e.g. the EXU main path and the address/branch path. Each requester issues operands over a valid/ready request channel and receives its result over a valid/ready response channel. The block accepts one operation at a time, latches the operands, runs the ALU and holds the result until the owning requester accepts it.

---
 rtl/ysyx_25060173_pkg.sv | 15 +
 rtl/ysyx_25060173_alu.sv | 14 +
 rtl/ysyx_25060173_alu_arb.sv | 100 ++++++++++
 tb/tb_ysyx_25060173_alu_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060173_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: datapath width, FSM encoding, ALU op codes.
package ysyx_25060173_pkg;

    localparam int XLEN = 32;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ALU_ADD = 1'b1;

endpackage

// File: rtl/ysyx_25060173_alu.sv
// Single-cycle 32-bit ALU: add when op is ALU_ADD, otherwise the result is forced to zero.
module ysyx_25060173_alu
    import ysyx_25060173_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            op,
    output logic [XLEN-1:0] result
);

    // Carry out is dropped; wrap-around is silent.
    assign result = (op == ALU_ADD) ? (src1 + src2) : '0;

endmodule

// File: rtl/ysyx_25060173_alu_arb.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one ALU between two requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module ysyx_25060173_alu_arb #(
    parameter int XLEN = ysyx_25060173_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_src1,
    input  logic [XLEN-1:0] req0_src2,
    input  logic            req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_src1,
    input  logic [XLEN-1:0] req1_src2,
    input  logic            req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            busy
);
    import ysyx_25060173_pkg::*;

    state_t          state;
    state_t          state_nxt;
    logic            prio;
    logic            owner;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic            op_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] alu_result;
    logic            grant0;
    logic            grant1;

    // Grants are only meaningful in IDLE and are held low while reset is asserted.
    assign grant0 = rst_n && (state == IDLE) && req0_valid && (!req1_valid || (prio == 1'b0));
    assign grant1 = rst_n && (state == IDLE) && req1_valid && (!req0_valid || (prio == 1'b1));

    ysyx_25060173_alu u_alu (
        .src1   (src1_q),
        .src2   (src2_q),
        .op     (op_q),
        .result (alu_result)
    );

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                // The winner gives up priority for the next contested cycle.
                owner  <= grant1;
                prio   <= grant0;
                src1_q <= grant1 ? req1_src1 : req0_src1;
                src2_q <= grant1 ? req1_src2 : req0_src2;
                op_q   <= grant1 ? req1_op : req0_op;
            end
            if (state == EXEC) result_q <= alu_result;
        end
    end

    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ysyx_25060173_alu_arb.sv
// Self-checking bench for the shared-ALU arbiter: vector table, directed corner sequences, random run.
module tb_ysyx_25060173_alu_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_op, rsp0_valid, rsp0_ready;
    logic [31:0] req0_src1, req0_src2, rsp0_result;
    logic        req1_valid, req1_ready, req1_op, rsp1_valid, rsp1_ready;
    logic [31:0] req1_src1, req1_src2, rsp1_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    ysyx_25060173_alu_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_src1   (req0_src1),
        .req0_src2   (req0_src2),
        .req0_op     (req0_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_src1   (req1_src1),
        .req1_src2   (req1_src2),
        .req1_op     (req1_op),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic op);
        if (k == 0) begin
            req0_valid = v; req0_src1 = a; req0_src2 = b; req0_op = op;
        end else begin
            req1_valid = v; req1_src1 = a; req1_src2 = b; req1_op = op;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) next_cycle();
        rst_n = 1'b1;
    endtask

    // One transaction from an idle start; returns at a negedge with the block idle again.
    task automatic do_txn(input int who, input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] exp, input int stall);
        int other;
        other = 1 - who;
        set_req(who, 1'b1, a, b, op);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check("txn_ready", (who == 0) ? req0_ready : req1_ready, 1'b1);
        check("txn_busy_idle", busy, 1'b0);
        next_cycle();
        set_req(who, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        check("txn_busy_exec", busy, 1'b1);
        check("txn_no_early_rsp", rsp0_valid | rsp1_valid, 1'b0);
        next_cycle();
        check("txn_rsp_valid", (who == 0) ? rsp0_valid : rsp1_valid, 1'b1);
        check("txn_other_rsp", (who == 0) ? rsp1_valid : rsp0_valid, 1'b0);
        check("txn_result", (who == 0) ? rsp0_result : rsp1_result, exp);
        check("txn_busy_resp", busy, 1'b1);
        for (int s = 0; s < stall; s++) begin
            set_req(other, 1'b1, 32'h55, 32'h66, 1'b1);
            #1;
            check("stall_other_ready", (other == 0) ? req0_ready : req1_ready, 1'b0);
            next_cycle();
            check("stall_valid_held", (who == 0) ? rsp0_valid : rsp1_valid, 1'b1);
            check("stall_result_held", (who == 0) ? rsp0_result : rsp1_result, exp);
        end
        set_req(other, 1'b0, 32'h0, 32'h0, 1'b0);
        if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        next_cycle();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("txn_back_idle", busy, 1'b0);
        check("txn_rsp_dropped", rsp0_valid | rsp1_valid, 1'b0);
    endtask

    // Both requesters always valid; grants must alternate starting with requester 0.
    task automatic contention();
        int c;
        int w;
        set_req(0, 1'b1, 32'h1, 32'h2, 1'b1);
        set_req(1, 1'b1, 32'h10, 32'h20, 1'b1);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        do_reset(2);
        #1;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            c = 0;
            while (!(req0_ready || req1_ready) && c < 8) begin
                next_cycle();
                c++;
            end
            check("cont_grant_seen", c < 8, 1'b1);
            check("cont_winner", (w == 0) ? req0_ready : req1_ready, 1'b1);
            check("cont_loser", (w == 0) ? req1_ready : req0_ready, 1'b0);
            next_cycle();
            c = 0;
            while (!((w == 0) ? rsp0_valid : rsp1_valid) && c < 8) begin
                next_cycle();
                c++;
            end
            check("cont_rsp_seen", c < 8, 1'b1);
            check("cont_result", (w == 0) ? rsp0_result : rsp1_result, (w == 0) ? 32'h3 : 32'h30);
            next_cycle();
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic random_run(input int cycles);
        logic        v[2];
        logic [31:0] a[2];
        logic [31:0] b[2];
        logic        op[2];
        logic        acc[2];
        logic        rr[2];
        logic        e_r0, e_r1, e_v0, e_v1, pend, m_prio;
        int          m_owner, m_age, w;
        m_prio = 1'b0;
        m_owner = 0;
        m_age = 0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; acc[k] = 1'b0; a[k] = '0; b[k] = '0; op[k] = 1'b0;
        end
        for (int t = 0; t < cycles; t++) begin
            for (int k = 0; k < 2; k++) begin
                // A pending valid stays asserted with stable operands until it is taken.
                if (!v[k] || acc[k]) begin
                    v[k]  = ($urandom_range(0, 2) != 0);
                    a[k]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b[k]  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
                    op[k] = ($urandom_range(0, 3) != 0);
                end
                rr[k] = ($urandom_range(0, 4) < 3);
                set_req(k, v[k], a[k], b[k], op[k]);
            end
            rsp0_ready = rr[0];
            rsp1_ready = rr[1];
            #1;
            pend = (exp_q.size() != 0);
            e_r0 = !pend && v[0] && (!v[1] || !m_prio);
            e_r1 = !pend && v[1] && (!v[0] || m_prio);
            e_v0 = pend && (m_age >= 2) && (m_owner == 0);
            e_v1 = pend && (m_age >= 2) && (m_owner == 1);
            check("rnd_req0_ready", req0_ready, e_r0);
            check("rnd_req1_ready", req1_ready, e_r1);
            check("rnd_rsp0_valid", rsp0_valid, e_v0);
            check("rnd_rsp1_valid", rsp1_valid, e_v1);
            check("rnd_busy", busy, pend);
            if (e_v0) check("rnd_rsp0_result", rsp0_result, exp_q[0]);
            if (e_v1) check("rnd_rsp1_result", rsp1_result, exp_q[0]);
            acc[0] = e_r0;
            acc[1] = e_r1;
            if (e_r0 || e_r1) begin
                w = e_r1 ? 1 : 0;
                exp_q.push_back(op[w] ? (a[w] + b[w]) : 32'h0);
                m_owner = w;
                m_age = 1;
                m_prio = (w == 0);
            end else if (pend) begin
                if (m_age >= 2 && rr[m_owner]) void'(exp_q.pop_front());
                else if (m_age < 2) m_age++;
            end
            next_cycle();
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 32'd5,          32'd7,          1'b1, 32'd12,         0};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'h1,          1'b1, 32'h0,          5};
        vecs[2] = '{0, 32'h1234,       32'h5678,       1'b0, 32'h0,          0};
        vecs[3] = '{1, 32'd3,          32'd4,          1'b1, 32'd7,          1};
        vecs[4] = '{0, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'h0,          2};
        vecs[5] = '{1, 32'h7FFF_FFFF,  32'h1,          1'b1, 32'h8000_0000,  0};
        vecs[6] = '{0, 32'h0,          32'h0,          1'b1, 32'h0,          0};
        vecs[7] = '{1, 32'hDEAD_BEEF,  32'h1,          1'b0, 32'h0,          3};

        rst_n = 1'b0;
        set_req(0, 1'b1, 32'h0, 32'h0, 1'b1);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);

        // Reset held with a request pending: everything must read zero.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_req0_ready", req0_ready, 1'b0);
            check("rst_rsp_valid", {31'b0, rsp0_valid | rsp1_valid}, 32'h0);
            check("rst_rsp0_result", rsp0_result, 32'h0);
            check("rst_rsp1_result", rsp1_result, 32'h0);
            check("rst_busy", busy, 1'b0);
            next_cycle();
        end
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", req0_ready, 1'b1);
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        next_cycle();

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].stall);

        contention();

        // Reset during EXEC drops the operation without a response.
        set_req(0, 1'b1, 32'd9, 32'd9, 1'b1);
        rsp0_ready = 1'b1;
        next_cycle();
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        check("midrst_in_exec", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("midrst_no_rsp", {31'b0, rsp0_valid | rsp1_valid}, 32'h0);
            next_cycle();
        end
        rsp0_ready = 1'b0;
        do_txn(1, 32'd3, 32'd4, 1'b1, 32'd7, 0);

        do_reset(2);
        random_run(1500);

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
